// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF and MEM stages.
// Defining ARB_PERF_CNT_EN adds grant and stall counters on the perf_* ports.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          err,
    output logic          busy,
    output logic [31:0]   perf_if_grants,
    output logic [31:0]   perf_dm_grants,
    output logic [31:0]   perf_stall_cycles
);
    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} stateT;
    stateT state;
    logic [3:0] starveCnt;
    logic [7:0] timer;
    logic dmWin, ifWin;
    // data wins unless IF has already lost STARVE_MAX arbitrations in a row
    assign dmWin = state == IDLE && dm_req && (starveCnt < 4'(STARVE_MAX) || !if_req);
    assign ifWin = state == IDLE && if_req && !dmWin;
    assign stall_if = if_req & ~if_done;
    assign stall_mem = dm_req & ~dm_done;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            starveCnt <= '0;
            timer <= '0;
            err <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_done <= 1'b0;
            dm_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    starveCnt <= (dmWin && if_req) ? starveCnt + 4'd1 : 4'd0;
                    if (dmWin) begin
                        state <= DM_ACC;
                        mem_req <= 1'b1;
                        mem_we <= dm_we;
                        mem_addr <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (ifWin) begin
                        state <= IF_ACC;
                        mem_req <= 1'b1;
                        mem_we <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                IF_ACC, DM_ACC: begin
                    if (mem_ready) begin
                        state <= DONE;
                        mem_req <= 1'b0;
                        mem_we <= 1'b0;
                        timer <= '0;
                        if (state == IF_ACC) begin
                            if_rdata <= mem_rdata;
                            if_done <= 1'b1;
                        end else begin
                            dm_done <= 1'b1;
                            if (!mem_we) dm_rdata <= mem_rdata;
                        end
                    end else begin
                        // err rises in the cycle the timer reads TIMEOUT; the access keeps waiting
                        timer <= (timer == 8'hFF) ? timer : timer + 8'd1;
                        if (timer == 8'(TIMEOUT - 1)) err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                end
            endcase
        end
    end
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_grants <= '0;
            perf_dm_grants <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_if_grants <= perf_if_grants + 32'(ifWin);
            perf_dm_grants <= perf_dm_grants + 32'(dmWin);
            perf_stall_cycles <= perf_stall_cycles + 32'(stall_if | stall_mem);
        end
    end
`else
    assign perf_if_grants = '0;
    assign perf_dm_grants = '0;
    assign perf_stall_cycles = '0;
`endif
endmodule
